// File: rtl/branch_history_table_pkg.sv
// Shared types and constants for the branch history table predictor.
package branch_history_table_pkg;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  localparam bht_state_t BHT_RESET_STATE = WNT;

endpackage

// File: rtl/branch_history_table_sat_ctr2.sv
// Next-state logic of a single 2-bit saturating direction counter.
module sat_ctr2
  import branch_history_table_pkg::*;
(
  input  bht_state_t i_state,
  input  logic       i_taken,
  output bht_state_t o_next_c
);

  always_comb begin
    o_next_c = i_state;
    unique case (i_state)
      SNT:     o_next_c = i_taken ? WNT : SNT;
      WNT:     o_next_c = i_taken ? WT  : SNT;
      WT:      o_next_c = i_taken ? ST  : WNT;
      ST:      o_next_c = i_taken ? ST  : WT;
      default: o_next_c = BHT_RESET_STATE;
    endcase
  end

endmodule

// File: rtl/branch_history_table.sv
// Dynamic branch predictor: PC-indexed table of 2-bit counters with mispredict tracking.
// Optional global-history (gshare) indexing when BHT_GSHARE_EN is defined.
module branch_history_table
  import branch_history_table_pkg::*;
#(
  parameter int unsigned IDX_BITS  = 6,
  parameter int unsigned HIST_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_W-1:0]     pred_pc,
  output logic                pred_taken,
  output logic [IDX_BITS-1:0] pred_idx,
  input  logic                upd_valid,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_br_en,
  input  logic                upd_pred,
  output logic                mispredict,
  output logic [CNT_W-1:0]    mispred_cnt
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  if (HIST_BITS > IDX_BITS) begin : g_bad_hist
    $error("HIST_BITS must not exceed IDX_BITS");
  end

  bht_state_t          r_table [ENTRIES];
  bht_state_t          w_upd_next;
  logic [IDX_BITS-1:0] w_pc_idx;
  logic                w_unused_pc;

  assign w_pc_idx    = pred_pc[IDX_BITS+1:2];
  assign w_unused_pc = ^{pred_pc[PC_W-1:IDX_BITS+2], pred_pc[1:0]};

`ifdef BHT_GSHARE_EN
  logic [HIST_BITS-1:0] r_ghr;

  // History advances only on resolved branches, never speculatively.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (upd_valid) begin
      r_ghr <= {r_ghr[HIST_BITS-2:0], upd_br_en};
    end
  end

  assign pred_idx = w_pc_idx ^ IDX_BITS'(r_ghr);
`else
  assign pred_idx = w_pc_idx;
`endif

  // Read is the registered table value: a same-cycle update is not bypassed.
  assign pred_taken = r_table[pred_idx][1];

  sat_ctr2 u_sat_ctr2 (
    .i_state  (r_table[upd_idx]),
    .i_taken  (upd_br_en),
    .o_next_c (w_upd_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_table[IDX_BITS'(i)] <= BHT_RESET_STATE;
      end
    end else if (upd_valid) begin
      r_table[upd_idx] <= w_upd_next;
    end
  end

  // Mispredict pulse and saturating event counter share one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict  <= 1'b0;
      mispred_cnt <= '0;
    end else begin
      mispredict <= upd_valid & (upd_br_en != upd_pred);
      if (upd_valid && (upd_br_en != upd_pred) && (mispred_cnt != '1)) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule
